// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the shared memory port arbiter.
// The slave modport is the arbiter view; the master modport is the pipeline/memory view.
interface mem_port_arbiter_if;
    logic        start_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_stall_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [31:0] d_rdata_o;
    logic        d_stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        err_o;
    logic [15:0] conflict_cnt_o;

    modport slave (
        input  start_i, if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
               mem_ack_i, mem_rdata_i,
        output if_rdata_o, if_stall_o, d_rdata_o, d_stall_o, mem_req_o, mem_we_o,
               mem_addr_o, mem_wdata_o, err_o, conflict_cnt_o
    );

    modport master (
        output start_i, if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
               mem_ack_i, mem_rdata_i,
        input  if_rdata_o, if_stall_o, d_rdata_o, d_stall_o, mem_req_o, mem_we_o,
               mem_addr_o, mem_wdata_o, err_o, conflict_cnt_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Data has priority; fetch is forced through after STARVE_LIMIT data grants.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 2);
    localparam int unsigned TW = $clog2(TIMEOUT + 2);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;
    logic        err_q, err_d;
    logic [15:0] conflict_q, conflict_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] timer_q, timer_d;

    logic gnt_valid;
    logic gnt_to_d;
    logic timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (timer_q == TIMER_LAST);

    // From DONE only the non-owner may be granted: the owner's request is stale that cycle.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_to_d  = 1'b0;
        if (bus.start_i) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.d_req_i && !(bus.if_req_i && starve_q == STARVE_MAX)) begin
                        gnt_valid = 1'b1;
                        gnt_to_d  = 1'b1;
                    end else if (bus.if_req_i) begin
                        gnt_valid = 1'b1;
                    end
                end
                S_DONE: begin
                    if (owner_q == OWN_D && bus.if_req_i) begin
                        gnt_valid = 1'b1;
                    end else if (owner_q == OWN_IF && bus.d_req_i) begin
                        gnt_valid = 1'b1;
                        gnt_to_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        err_d       = err_q;
        conflict_d  = conflict_q;
        starve_d    = starve_q;
        timer_d     = timer_q;

        case (state_q)
            S_IDLE: begin
                if (gnt_valid) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (bus.mem_ack_i) begin
                    state_d = S_DONE;
                    if (owner_q == OWN_IF) if_rdata_d = bus.mem_rdata_i;
                    else if (!mem_we_q)    d_rdata_d  = bus.mem_rdata_i;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    if (owner_q == OWN_IF) if_rdata_d = '0;
                    else                   d_rdata_d  = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = gnt_valid ? S_ACCESS : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (gnt_valid) begin
            owner_d     = gnt_to_d ? OWN_D : OWN_IF;
            mem_addr_d  = gnt_to_d ? bus.d_addr_i : bus.if_addr_i;
            mem_we_d    = gnt_to_d & bus.d_we_i;
            mem_wdata_d = gnt_to_d ? bus.d_wdata_i : '0;
            timer_d     = '0;
        end

        if (!bus.if_req_i || (gnt_valid && !gnt_to_d)) begin
            starve_d = '0;
        end else if (gnt_valid && gnt_to_d && starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
        end

        if ((state_q == S_ACCESS || state_q == S_DONE) && owner_q == OWN_D &&
            bus.if_req_i && conflict_q != '1) begin
            conflict_d = conflict_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_NONE;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            err_q       <= 1'b0;
            conflict_q  <= '0;
            starve_q    <= '0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            err_q       <= err_d;
            conflict_q  <= conflict_d;
            starve_q    <= starve_d;
            timer_q     <= timer_d;
        end
    end

    assign bus.mem_req_o      = (state_q == S_ACCESS);
    assign bus.mem_we_o       = mem_we_q;
    assign bus.mem_addr_o     = mem_addr_q;
    assign bus.mem_wdata_o    = mem_wdata_q;
    assign bus.if_rdata_o     = if_rdata_q;
    assign bus.d_rdata_o      = d_rdata_q;
    assign bus.err_o          = err_q;
    assign bus.conflict_cnt_o = conflict_q;
    assign bus.if_stall_o     = bus.if_req_i & ~(state_q == S_DONE && owner_q == OWN_IF);
    assign bus.d_stall_o      = bus.d_req_i  & ~(state_q == S_DONE && owner_q == OWN_D);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: memory model with programmable ack latency,
// release monitor popping expected read data from per-requester scoreboards.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [31:0] if_q[$];
    logic [31:0] d_q[$];
    logic [31:0] mem_arr [64];
    int          lat = 0;
    bit          hang = 1'b0;
    int          acc_cnt = 0;
    int          cyc = 0;
    int          if_served = 0, d_served = 0;
    int          if_serve_cyc = 0, d_serve_cyc = 0;
    int          mreq_cycles = 0, if_stall_cycles = 0;
    logic        acc_we = 1'b0;
    logic [31:0] acc_addr = '0, acc_wdata = '0;
    bit          if_drop = 1'b0, d_drop = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Memory model: ack after `lat` extra ACCESS cycles unless hung.
    always @(negedge clk) begin
        if (bus.mem_req_o) begin
            if (acc_cnt == lat && !hang) begin
                bus.mem_ack_i   = 1'b1;
                bus.mem_rdata_i = mem_arr[bus.mem_addr_o[7:2]];
                if (bus.mem_we_o) mem_arr[bus.mem_addr_o[7:2]] = bus.mem_wdata_o;
            end else begin
                bus.mem_ack_i   = 1'b0;
                bus.mem_rdata_i = 32'hDEAD_BEEF;
            end
            acc_cnt++;
        end else begin
            bus.mem_ack_i = 1'b0;
            acc_cnt = 0;
        end
    end

    // Release monitor and scoreboard compare.
    always @(negedge clk) begin
        logic [31:0] exp;
        cyc++;
        if (bus.mem_req_o) begin
            mreq_cycles++;
            acc_we    = bus.mem_we_o;
            acc_addr  = bus.mem_addr_o;
            acc_wdata = bus.mem_wdata_o;
        end
        if (bus.if_req_i && bus.if_stall_o) if_stall_cycles++;
        if (!rst && bus.if_req_i && !bus.if_stall_o) begin
            check("if_release_expected", 32'(if_q.size() != 0), 32'd1);
            if (if_q.size() != 0) begin
                exp = if_q.pop_front();
                check("if_rdata", bus.if_rdata_o, exp);
            end
            if_served++;
            if_serve_cyc = cyc;
            if_drop = 1'b1;
        end
        if (!rst && bus.d_req_i && !bus.d_stall_o) begin
            check("d_release_expected", 32'(d_q.size() != 0), 32'd1);
            if (d_q.size() != 0) begin
                exp = d_q.pop_front();
                check("d_rdata", bus.d_rdata_o, exp);
            end
            d_served++;
            d_serve_cyc = cyc;
            d_drop = 1'b1;
        end
    end

    // Requesters drop their request on the edge that ends the DONE cycle.
    always begin
        @(posedge clk);
        #1;
        if (if_drop) begin bus.if_req_i = 1'b0; if_drop = 1'b0; end
        if (d_drop)  begin bus.d_req_i  = 1'b0; d_drop  = 1'b0; end
    end

    task automatic issue_if(input logic [31:0] addr, input logic [31:0] exp);
        bus.if_addr_i = addr;
        bus.if_req_i  = 1'b1;
        if_q.push_back(exp);
    endtask

    task automatic issue_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp);
        bus.d_we_i    = we;
        bus.d_addr_i  = addr;
        bus.d_wdata_i = wdata;
        bus.d_req_i   = 1'b1;
        d_q.push_back(exp);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((if_q.size() + d_q.size()) != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 60), 32'd1);
        @(posedge clk);
        #2;
    endtask

    task automatic wait_d(input string tag);
        int n = 0;
        while (d_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 60), 32'd1);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int d_before, if_before, n;
        bus.start_i = 1'b1;   bus.if_req_i = 1'b0;  bus.if_addr_i = '0;
        bus.d_req_i = 1'b0;   bus.d_we_i = 1'b0;    bus.d_addr_i = '0;
        bus.d_wdata_i = '0;   bus.mem_ack_i = 1'b0; bus.mem_rdata_i = '0;
        for (int i = 0; i < 64; i++) mem_arr[i] = 32'h1000_0000 + 32'(i);
        mem_arr[1]  = 32'h1111_1111;
        mem_arr[2]  = 32'h2222_2222;
        mem_arr[4]  = 32'h00A0_0093;
        mem_arr[8]  = 32'h3333_3333;
        mem_arr[12] = 32'h4444_4444;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req",   32'(bus.mem_req_o), 32'd0);
        check("rst_mem_we",    32'(bus.mem_we_o), 32'd0);
        check("rst_mem_addr",  bus.mem_addr_o, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata_o, 32'd0);
        check("rst_if_rdata",  bus.if_rdata_o, 32'd0);
        check("rst_d_rdata",   bus.d_rdata_o, 32'd0);
        check("rst_err",       32'(bus.err_o), 32'd0);
        check("rst_conflict",  32'(bus.conflict_cnt_o), 32'd0);
        check("rst_stalls",    32'({bus.if_stall_o, bus.d_stall_o}), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #2;

        // 1: lone fetch, ack in second ACCESS cycle
        lat = 1; mreq_cycles = 0; if_stall_cycles = 0;
        issue_if(32'h10, 32'h00A0_0093);
        wait_drain("t1_done");
        check("t1_mreq_cycles", 32'(mreq_cycles), 32'd2);
        check("t1_stall_cycles", 32'(if_stall_cycles), 32'd3);
        check("t1_mem_we", 32'(acc_we), 32'd0);
        check("t1_mem_addr", acc_addr, 32'h10);

        // 2: simultaneous requests, D first, IF handed over from D DONE
        lat = 0; mreq_cycles = 0;
        issue_if(32'h04, 32'h1111_1111);
        issue_d(1'b0, 32'h08, 32'h0, 32'h2222_2222);
        wait_drain("t2_done");
        check("t2_handover_gap", 32'(if_serve_cyc - d_serve_cyc), 32'd2);
        check("t2_conflict", 32'(bus.conflict_cnt_o), 32'd2);
        check("t2_mreq_cycles", 32'(mreq_cycles), 32'd2);

        // 3: IF pending while D is granted from IDLE four times; fifth grant goes to IF
        bus.start_i = 1'b0;
        issue_if(32'h20, 32'h3333_3333);
        d_before = d_served; if_before = if_served;
        for (int k = 0; k < 4; k++) begin
            issue_d(1'b0, 32'h08, 32'h0, 32'h2222_2222);
            bus.start_i = 1'b1;
            @(posedge clk);
            #2 bus.start_i = 1'b0;
            wait_d("t3_d_done");
        end
        check("t3_d_grants", 32'(d_served - d_before), 32'd4);
        check("t3_if_waiting", 32'(if_served - if_before), 32'd0);
        check("t3_if_stalled", 32'(bus.if_stall_o), 32'd1);
        issue_d(1'b0, 32'h08, 32'h0, 32'h2222_2222);
        bus.start_i = 1'b1;
        wait_drain("t3_done");
        check("t3_if_before_d", 32'(if_serve_cyc < d_serve_cyc), 32'd1);
        check("t3_d_total", 32'(d_served - d_before), 32'd5);
        check("t3_conflict", 32'(bus.conflict_cnt_o), 32'd10);

        // 4: data write leaves d_rdata_o untouched, then read it back
        issue_d(1'b1, 32'h0C, 32'd5, 32'h2222_2222);
        wait_drain("t4_done");
        check("t4_mem_we", 32'(acc_we), 32'd1);
        check("t4_mem_addr", acc_addr, 32'h0C);
        check("t4_mem_wdata", acc_wdata, 32'd5);
        issue_d(1'b0, 32'h0C, 32'h0, 32'd5);
        wait_drain("t4_readback");

        // 5: memory never acks, access aborted after 8 cycles
        check("t5_err_before", 32'(bus.err_o), 32'd0);
        hang = 1'b1; mreq_cycles = 0;
        issue_if(32'h30, 32'h0);
        wait_drain("t5_done");
        check("t5_mreq_cycles", 32'(mreq_cycles), 32'd8);
        check("t5_err", 32'(bus.err_o), 32'd1);
        hang = 1'b0;
        issue_d(1'b0, 32'h08, 32'h0, 32'h2222_2222);
        wait_drain("t5_after");
        check("t5_err_sticky", 32'(bus.err_o), 32'd1);

        // 6: reset mid-access, then start_i low blocks grants
        hang = 1'b1;
        issue_if(32'h04, 32'h0);
        issue_d(1'b0, 32'h08, 32'h0, 32'h0);
        n = 0;
        while (!bus.mem_req_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_access_seen", 32'(n < 20), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_rst_mem_req", 32'(bus.mem_req_o), 32'd0);
        check("t6_rst_conflict", 32'(bus.conflict_cnt_o), 32'd0);
        check("t6_rst_err", 32'(bus.err_o), 32'd0);
        bus.if_req_i = 1'b0; bus.d_req_i = 1'b0;
        if_q.delete(); d_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b0; bus.start_i = 1'b0; hang = 1'b0; mreq_cycles = 0;
        issue_if(32'h04, 32'h1111_1111);
        issue_d(1'b0, 32'h0C, 32'h0, 32'd5);
        repeat (5) @(posedge clk);
        #1;
        check("t6_no_grant", 32'(mreq_cycles), 32'd0);
        check("t6_stalls_held", 32'({bus.if_stall_o, bus.d_stall_o}), 32'd3);
        bus.start_i = 1'b1;
        wait_drain("t6_done");
        check("final_queues_empty", 32'(if_q.size() + d_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
